// File: rtl/alu_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_uart_pkg
// Brief   : Shared state encoding, opcode defaults and status-bit positions
//           for the UART/ALU frame sequencer.
// Revision: 1.0
// ============================================================================
package alu_uart_pkg;

   localparam logic [2:0] c_ST_WAIT_A    = 3'd0;
   localparam logic [2:0] c_ST_WAIT_B    = 3'd1;
   localparam logic [2:0] c_ST_WAIT_OP   = 3'd2;
   localparam logic [2:0] c_ST_EXEC      = 3'd3;
   localparam logic [2:0] c_ST_TX_RES    = 3'd4;
   localparam logic [2:0] c_ST_WAIT_RES  = 3'd5;
   localparam logic [2:0] c_ST_TX_STAT   = 3'd6;
   localparam logic [2:0] c_ST_WAIT_STAT = 3'd7;

   typedef enum logic [2:0] {
      S_WAIT_A    = c_ST_WAIT_A,
      S_WAIT_B    = c_ST_WAIT_B,
      S_WAIT_OP   = c_ST_WAIT_OP,
      S_EXEC      = c_ST_EXEC,
      S_TX_RES    = c_ST_TX_RES,
      S_WAIT_RES  = c_ST_WAIT_RES,
      S_TX_STAT   = c_ST_TX_STAT,
      S_WAIT_STAT = c_ST_WAIT_STAT
   } seq_state_t;

   localparam logic [7:0] c_OP_ADD = 8'h20;
   localparam logic [7:0] c_OP_SUB = 8'h22;

   localparam int c_STAT_OVF_BIT = 0;
   localparam int c_STAT_ERR_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/alu_seq_timeout.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_timeout
// Brief   : Inter-byte timeout counter; cleared on demand, counts while
//           enabled, flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
// Revision: 1.0
// ============================================================================
module alu_seq_timeout #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int                 c_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_WIDTH-1:0] c_LAST  = c_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [c_WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + c_WIDTH'(1);
      end
   end

   assign o_expire = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/alu_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_uart_sequencer
// Brief   : Collects A, B, opcode over UART, drives ADD_SUB, returns result
//           and status bytes. Optional inter-byte timeout: ALU_SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module alu_uart_sequencer
   import alu_uart_pkg::*;
#(
   parameter int                 NB_DATA        = 8,
   parameter logic [NB_DATA-1:0] OP_ADD         = c_OP_ADD,
   parameter logic [NB_DATA-1:0] OP_SUB         = c_OP_SUB,
   parameter int                 TIMEOUT_CYCLES = 100000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_alu_overflow,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic               o_alu_ctrl,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy
);

   seq_state_t         r_state;
   seq_state_t         w_state_next;
   logic [NB_DATA-1:0] r_alu_a;
   logic [NB_DATA-1:0] r_alu_b;
   logic               r_ctrl;
   logic               r_err;
   logic [NB_DATA-1:0] r_res;
   logic [NB_DATA-1:0] r_stat;
   logic [NB_DATA-1:0] w_stat;
   logic               w_timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
   logic w_cnt_en;
   logic w_cnt_clr;

   // Any received byte in a waiting state is accepted, so rx_done alone clears.
   assign w_cnt_en  = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);
   assign w_cnt_clr = i_rx_done || !w_cnt_en;

   alu_seq_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_rst    (i_reset),
      .i_clear  (w_cnt_clr),
      .i_enable (w_cnt_en),
      .o_expire (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_WAIT_A;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_WAIT_A:    if (i_rx_done) w_state_next = S_WAIT_B;
         S_WAIT_B:    if (i_rx_done) w_state_next = S_WAIT_OP;
                      else if (w_timeout) w_state_next = S_WAIT_A;
         S_WAIT_OP:   if (i_rx_done) w_state_next = S_EXEC;
                      else if (w_timeout) w_state_next = S_WAIT_A;
         S_EXEC:      w_state_next = S_TX_RES;
         S_TX_RES:    w_state_next = S_WAIT_RES;
         S_WAIT_RES:  if (i_tx_done) w_state_next = S_TX_STAT;
         S_TX_STAT:   w_state_next = S_WAIT_STAT;
         S_WAIT_STAT: if (i_tx_done) w_state_next = S_WAIT_A;
         default:     w_state_next = S_WAIT_A;
      endcase
   end

   // An invalid opcode forces a zero result and suppresses the ALU overflow.
   always_comb begin
      w_stat                 = '0;
      w_stat[c_STAT_ERR_BIT] = r_err;
      w_stat[c_STAT_OVF_BIT] = !r_err && i_alu_overflow;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_alu_a <= '0;
         r_alu_b <= '0;
         r_ctrl  <= 1'b0;
         r_err   <= 1'b0;
         r_res   <= '0;
         r_stat  <= '0;
      end else begin
         case (r_state)
            S_WAIT_A:  if (i_rx_done) r_alu_a <= i_rx_data;
            S_WAIT_B:  if (i_rx_done) r_alu_b <= i_rx_data;
            S_WAIT_OP: if (i_rx_done) begin
               r_ctrl <= (i_rx_data == OP_SUB);
               r_err  <= (i_rx_data != OP_ADD) && (i_rx_data != OP_SUB);
            end
            S_EXEC: begin
               r_res  <= r_err ? '0 : i_alu_result;
               r_stat <= w_stat;
            end
            S_WAIT_STAT: if (i_tx_done) r_err <= 1'b0;
            default: ;
         endcase
      end
   end

   assign o_alu_a    = r_alu_a;
   assign o_alu_b    = r_alu_b;
   assign o_alu_ctrl = r_ctrl;
   assign o_tx_start = (r_state == S_TX_RES) || (r_state == S_TX_STAT);
   assign o_tx_data  = ((r_state == S_TX_STAT) || (r_state == S_WAIT_STAT)) ? r_stat : r_res;
   assign o_busy     = (r_state != S_WAIT_A);

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_uart_sequencer
// Brief   : Directed and randomized frame bench with an arithmetic reference
//           model and a behavioural ADD_SUB neighbour.
// Revision: 1.0
// ============================================================================
module tb_alu_uart_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] alu_res;
   logic       alu_ovf;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic       alu_ctrl;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_uart_sequencer #(
      .NB_DATA        (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_rx_data      (rx_data),
      .i_rx_done      (rx_done),
      .i_tx_done      (tx_done),
      .i_alu_result   (alu_res),
      .i_alu_overflow (alu_ovf),
      .o_alu_a        (alu_a),
      .o_alu_b        (alu_b),
      .o_alu_ctrl     (alu_ctrl),
      .o_tx_data      (tx_data),
      .o_tx_start     (tx_start),
      .o_busy         (busy)
   );

   // Neighbouring ADD_SUB unit: wrapping signed add/sub with overflow flag.
   always_comb begin
      alu_res = alu_ctrl ? (alu_a - alu_b) : (alu_a + alu_b);
      alu_ovf = alu_ctrl ? ((alu_a[7] != alu_b[7]) && (alu_res[7] != alu_a[7]))
                         : ((alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]));
   end

   // Reference: {result byte, status byte} for one frame.
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op);
      int          sa;
      int          sb;
      int          r;
      logic [31:0] rv;
      logic        ovf;
      if (op != 8'h20 && op != 8'h22) return {8'h00, 8'h02};
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      r   = (op == 8'h22) ? sa - sb : sa + sb;
      ovf = (r > 127) || (r < -128);
      rv  = r;
      return {rv[7:0], 7'b0, ovf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input int gap, input bit poke);
      logic [15:0] m;
      m = model(a, b, op);
      send_byte(a);
      repeat (gap) tick();
      send_byte(b);
      repeat (gap) tick();
      send_byte(op);
      check("exec_no_start", tx_start, 0);
      tick();
      check("res_start", tx_start, 1);
      check("res_data", tx_data, m[15:8]);
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
      check("alu_ctrl", alu_ctrl, op == 8'h22);
      tick();
      check("res_single_pulse", tx_start, 0);
      check("res_data_hold", tx_data, m[15:8]);
      if (poke) begin
         send_byte(8'($urandom));
         check("rx_drop_wait_res", tx_start, 0);
         rx_data = 8'($urandom);
         rx_done = 1'b1;
      end else begin
         repeat (gap) tick();
      end
      pulse_tx_done();
      rx_done = 1'b0;
      check("stat_start", tx_start, 1);
      check("stat_data", tx_data, m[7:0]);
      tick();
      repeat (gap) tick();
      check("busy_wait_stat", busy, 1);
      pulse_tx_done();
      check("idle_after_frame", busy, 0);
      check("hold_a", alu_a, a);
      check("hold_b", alu_b, b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] op;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_ctrl", alu_ctrl, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", busy, 0);

      pulse_tx_done();
      check("tx_done_ignored_idle", busy, 0);

      run_frame(8'h05, 8'h03, 8'h20, 0, 1'b0);
      run_frame(8'h7F, 8'h01, 8'h20, 1, 1'b0);
      run_frame(8'h80, 8'h01, 8'h22, 0, 1'b1);
      run_frame(8'h05, 8'h03, 8'h3F, 2, 1'b0);
      run_frame(8'h02, 8'h02, 8'h22, 0, 1'b0);

      send_byte(8'h05);
      send_byte(8'h03);
      check("partial_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_alu_a", alu_a, 0);
      check("mid_rst_alu_b", alu_b, 0);
      check("mid_rst_tx_start", tx_start, 0);
      check("mid_rst_tx_data", tx_data, 0);
      run_frame(8'h01, 8'h01, 8'h20, 0, 1'b0);

`ifdef ALU_SEQ_TIMEOUT_EN
      send_byte(8'h05);
      for (int i = 0; i < 16; i++) begin
         if (i == 8) check("timeout_still_busy", busy, 1);
         tick();
         check("timeout_no_start", tx_start, 0);
      end
      check("timeout_back_idle", busy, 0);
      run_frame(8'h01, 8'h02, 8'h20, 0, 1'b1);
`endif

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0, 1:    op = 8'h20;
            2:       op = 8'h22;
            default: op = 8'($urandom);
         endcase
         run_frame(8'($urandom), 8'($urandom), op, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
